// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg
// Shared types and constants for the iterative AES-128 round controller:
// the controller FSM encoding, state/key width, default round count,
// reset value of the ShiftRows offsets and the round-key index width.
package aes_ctrl_pkg;

    localparam int          AES_DW         = 128;
    localparam int          AES_NR_DEFAULT = 10;
    localparam int          RK_IDX_W       = 4;
    // Row r offset lives in bits [2r+1:2r]; E4 = rows 3..0 shifted by 3,2,1,0.
    localparam logic [7:0]  SHIFT_DEFAULT  = 8'hE4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KREQ  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if
// Bundles every non-clock signal of the round controller:
//   block input   : in_valid, in_ready, in_data
//   key expander  : rk_req, rk_idx, rk_valid, rk_data
//   round datapath: dp_state, dp_rk, dp_last, dp_result, shift_sel
//   offset config : cfg_we, cfg_shift, cfg_err
//   block output  : out_valid, out_ready, out_data
//   status        : busy, round
// master = controller side, slave = surrounding system (producer, key
// expander, datapath, consumer).
interface aes_round_ctrl_if
    import aes_ctrl_pkg::*;
#(
    parameter int DW = AES_DW
) ();

    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;

    logic                rk_req;
    logic [RK_IDX_W-1:0] rk_idx;
    logic                rk_valid;
    logic [DW-1:0]       rk_data;

    logic [DW-1:0]       dp_state;
    logic [DW-1:0]       dp_rk;
    logic                dp_last;
    logic [DW-1:0]       dp_result;
    logic [7:0]          shift_sel;

    logic                cfg_we;
    logic [7:0]          cfg_shift;
    logic                cfg_err;

    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;

    logic                busy;
    logic [RK_IDX_W-1:0] round;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output rk_req, rk_idx,
        input  rk_valid, rk_data,
        output dp_state, dp_rk, dp_last, shift_sel,
        input  dp_result,
        input  cfg_we, cfg_shift,
        output cfg_err,
        output out_valid, out_data,
        input  out_ready,
        output busy, round
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  rk_req, rk_idx,
        output rk_valid, rk_data,
        input  dp_state, dp_rk, dp_last, shift_sel,
        output dp_result,
        output cfg_we, cfg_shift,
        input  cfg_err,
        input  out_valid, out_data,
        output out_ready,
        input  busy, round
    );

endinterface

// File: rtl/aes_shift_cfg.sv
// aes_shift_cfg
// Holds the per-row ShiftRows offsets. Writes are only taken while the
// controller is idle so a block always runs with one fixed set of offsets;
// a write arriving while busy is dropped and flagged with a one-cycle
// cfg_err pulse on the following cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   cfg_we      write strobe
//   cfg_shift   new offsets, row r in [2r+1:2r]
//   idle        controller FSM is in IDLE
//   shift_sel   active offsets (resets to standard AES)
//   cfg_err     write rejected (registered pulse)
module aes_shift_cfg
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [7:0] cfg_shift,
    input  logic       idle,
    output logic [7:0] shift_sel,
    output logic       cfg_err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_sel <= SHIFT_DEFAULT;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~idle;
            // A write in the same IDLE cycle as block acceptance lands at the
            // same edge, so that block already sees the new offsets.
            if (cfg_we && idle) begin
                shift_sel <= cfg_shift;
            end
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Iterative AES-128 encryption controller. Owns the 128-bit state register,
// the round counter and the round-key register, and sequences an external
// combinational round datapath over NR rounds. Round keys are fetched one at
// a time from an external key expander.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         aes_round_ctrl_if.master: block input/output handshakes,
//               key request, datapath hookup, offset config, status
// Parameters:
//   NR  number of rounds (1..14)
//   DW  state/key width (128)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a plaintext block; offsets may be written
// ST_KREQ  | requesting round key `round`; key 0 is XORed in directly
// ST_ROUND | one cycle: state_reg takes the datapath result
// ST_DONE  | ciphertext offered until the consumer accepts it
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR = AES_NR_DEFAULT,
    parameter int DW = AES_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_round_ctrl_if.master  bus
);

    localparam logic [RK_IDX_W-1:0] NR_L = RK_IDX_W'(NR);

    ctrl_state_t         st;
    logic [DW-1:0]       state_reg;
    logic [DW-1:0]       rk_reg;
    logic [RK_IDX_W-1:0] rnd;
    logic                idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            state_reg <= '0;
            rk_reg    <= '0;
            rnd       <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= bus.in_data;
                        rnd       <= '0;
                        st        <= ST_KREQ;
                    end
                end
                ST_KREQ: begin
                    if (bus.rk_valid) begin
                        if (rnd == '0) begin
                            // Initial AddRoundKey needs no datapath pass.
                            state_reg <= state_reg ^ bus.rk_data;
                            rnd       <= RK_IDX_W'(1);
                        end else begin
                            rk_reg <= bus.rk_data;
                            st     <= ST_ROUND;
                        end
                    end
                end
                ST_ROUND: begin
                    state_reg <= bus.dp_result;
                    if (rnd == NR_L) begin
                        st <= ST_DONE;
                    end else begin
                        rnd <= rnd + RK_IDX_W'(1);
                        st  <= ST_KREQ;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign idle = (st == ST_IDLE);

    // Decoded purely from registers, so no input reaches an output
    // combinationally.
    assign bus.in_ready  = idle;
    assign bus.rk_req    = (st == ST_KREQ);
    assign bus.out_valid = (st == ST_DONE);
    assign bus.busy      = ~idle;
    assign bus.dp_last   = (st == ST_ROUND) && (rnd == NR_L);

    assign bus.rk_idx    = rnd;
    assign bus.round     = rnd;
    assign bus.dp_state  = state_reg;
    assign bus.dp_rk     = rk_reg;
    // state_reg is frozen in DONE, which keeps out_data stable under stall.
    assign bus.out_data  = state_reg;

    aes_shift_cfg u_shift_cfg (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (bus.cfg_we),
        .cfg_shift (bus.cfg_shift),
        .idle      (idle),
        .shift_sel (bus.shift_sel),
        .cfg_err   (bus.cfg_err)
    );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl
// Drives the controller with a behavioural AES environment: a key expander
// with programmable response delay, a combinational round datapath honouring
// the dynamic ShiftRows offsets, and a reference encryptor that computes the
// expected ciphertext directly from plaintext, key and offsets.
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    localparam int NR = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;
    int   key_delay = 0;
    int   wait_cnt  = 0;
    int   last_cnt  = 0;
    logic [127:0] rkeys [0:15];

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(.NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.dp_last === 1'b1) last_cnt <= last_cnt + 1;

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return r;
    endfunction

    // Multiplicative inverse as a^254, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, r;
        r = 8'h01; p = a;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        if (a == 8'h00) r = 8'h00;
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] st, input logic [127:0] rk,
                                              input logic last, input logic [7:0] sel);
        logic [7:0]   b [16];
        logic [7:0]   s [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        int           off;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int r = 0; r < 4; r++) begin
            off = int'(sel[2*r +: 2]);
            for (int c = 0; c < 4; c++) s[r + 4*c] = b[r + 4*((c + off) % 4)];
        end
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                s[4*c]   = xt(a0) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                s[4*c+1] = a0 ^ xt(a1) ^ gf_mul(a2, 8'h03) ^ a3;
                s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ gf_mul(a3, 8'h03);
                s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o ^ rk;
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rkeys[r] = '0;
        for (int r = 0; r <= 10; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [7:0] sel);
        logic [127:0] s;
        s = pt ^ rkeys[0];
        for (int r = 1; r <= NR; r++) s = round_fn(s, rkeys[r], r == NR, sel);
        return s;
    endfunction

    // ---------------- environment models ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (!bus.rk_req || bus.rk_valid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    assign bus.rk_valid = bus.rk_req && (wait_cnt >= key_delay);
    assign bus.rk_data  = rkeys[bus.rk_idx];
    always_comb bus.dp_result = round_fn(bus.dp_state, bus.dp_rk, bus.dp_last, bus.shift_sel);

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_out(input int t0, output int lat, output logic [127:0] ct);
        lat = -1; ct = '0;
        for (int n = 0; n < 2000; n++) begin
            if (bus.out_valid === 1'b1) begin
                lat = cyc - t0;
                ct  = bus.out_data;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Latency is counted from the cycle in which in_valid && in_ready is
    // presented to the cycle in which out_valid is first seen high.
    task automatic run_block(input logic [127:0] pt, input int dly,
                             output logic [127:0] ct, output int lat);
        int t0;
        int n;
        key_delay = dly;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        bus.in_valid = 1'b1; bus.in_data = pt; t0 = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_data = rand128();
        wait_out(t0, lat, ct);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.rk_req, bus.cfg_err, bus.busy, bus.dp_last} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 100000", {bus.in_ready, bus.out_valid, bus.rk_req, bus.cfg_err, bus.busy, bus.dp_last});
        end
        checks++;
        if ({bus.round, bus.rk_idx} !== 8'h00) begin
            errors++; $display("FAIL reset_round: got %h expected 00", {bus.round, bus.rk_idx});
        end
        checks++;
        if (bus.shift_sel !== 8'hE4) begin
            errors++; $display("FAIL reset_shift: got %h expected e4", bus.shift_sel);
        end
        checks++;
        if ({bus.dp_state, bus.dp_rk, bus.out_data} !== 384'h0) begin
            errors++; $display("FAIL reset_data: dp_state=%h dp_rk=%h out_data=%h expected 0", bus.dp_state, bus.dp_rk, bus.out_data);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips;
        logic [127:0] ct;
        int lat, c0;
        set_key(128'h000102030405060708090a0b0c0d0e0f);
        c0 = last_cnt;
        run_block(128'h00112233445566778899aabbccddeeff, 0, ct, lat);
        checks++;
        if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            errors++; $display("FAIL fips_ct: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", ct);
        end
        checks++;
        if (lat !== 22) begin errors++; $display("FAIL fips_latency: got %0d expected 22", lat); end
        checks++;
        if (last_cnt - c0 !== 1) begin errors++; $display("FAIL fips_dp_last: got %0d cycles expected 1", last_cnt - c0); end
    endtask

    task automatic test_key_stalls;
        logic [127:0] ct;
        int lat;
        run_block(128'h00112233445566778899aabbccddeeff, 3, ct, lat);
        checks++;
        if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            errors++; $display("FAIL stall_ct: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", ct);
        end
        checks++;
        if (lat !== 55) begin errors++; $display("FAIL stall_latency: got %0d expected 55", lat); end
        key_delay = 0;
    endtask

    task automatic test_backpressure;
        logic [127:0] pt1, pt2, ct, ct2;
        int t0, lat, bad;
        set_key(rand128());
        pt1 = rand128(); pt2 = rand128();
        key_delay = 0; bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = pt1; t0 = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(t0, lat, ct);
        checks++;
        if (ct !== ref_encrypt(pt1, 8'hE4)) begin
            errors++; $display("FAIL bp_ct1: got %h expected %h", ct, ref_encrypt(pt1, 8'hE4));
        end
        bus.in_valid = 1'b1; bus.in_data = pt2;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== ct || bus.in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++; $display("FAIL bp_release: in_ready,out_valid got %b expected 10", {bus.in_ready, bus.out_valid});
        end
        t0 = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_accept2: busy got %b expected 1", bus.busy); end
        wait_out(t0, lat, ct2);
        checks++;
        if (ct2 !== ref_encrypt(pt2, 8'hE4) || lat !== 22) begin
            errors++; $display("FAIL bp_block2: got %h lat %0d expected %h lat 22", ct2, lat, ref_encrypt(pt2, 8'hE4));
        end
        @(negedge clk);
    endtask

    task automatic test_cfg_lock;
        logic [127:0] pt, ct;
        int t0, lat, n, dly;
        set_key(rand128());
        pt = rand128(); dly = $urandom_range(0, 2);
        key_delay = dly; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = pt; t0 = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.round !== 4'd4 && n < 200) begin @(negedge clk); n++; end
        bus.cfg_we = 1'b1; bus.cfg_shift = 8'h1B;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        checks++;
        if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL lock_err_pulse: got %b expected 1", bus.cfg_err); end
        @(negedge clk);
        checks++;
        if ({bus.cfg_err, bus.shift_sel} !== {1'b0, 8'hE4}) begin
            errors++; $display("FAIL lock_shift: cfg_err=%b shift_sel=%h expected 0 e4", bus.cfg_err, bus.shift_sel);
        end
        wait_out(t0, lat, ct);
        checks++;
        if (ct !== ref_encrypt(pt, 8'hE4) || lat !== 22 + 11*dly) begin
            errors++; $display("FAIL lock_ct: got %h lat %0d expected %h lat %0d", ct, lat, ref_encrypt(pt, 8'hE4), 22 + 11*dly);
        end
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_shift = 8'h1B;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        checks++;
        if ({bus.cfg_err, bus.shift_sel} !== {1'b0, 8'h1B}) begin
            errors++; $display("FAIL idle_write: cfg_err=%b shift_sel=%h expected 0 1b", bus.cfg_err, bus.shift_sel);
        end
        pt = rand128();
        run_block(pt, 0, ct, lat);
        checks++;
        if (ct !== ref_encrypt(pt, 8'h1B)) begin
            errors++; $display("FAIL shift1b_ct: got %h expected %h", ct, ref_encrypt(pt, 8'h1B));
        end
    endtask

    task automatic test_reset_midop;
        logic [127:0] pt, ct;
        int n, seen, lat;
        set_key(rand128());
        key_delay = $urandom_range(0, 2); bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = rand128();
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.round !== 4'd5 && n < 200) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.rk_req, bus.cfg_err, bus.busy, bus.dp_last, bus.round, bus.rk_idx, bus.shift_sel} !== {6'b100000, 8'h00, 8'hE4}) begin
            errors++;
            $display("FAIL midop_ctrl: got %b %h %h expected 100000 00 e4", {bus.in_ready, bus.out_valid, bus.rk_req, bus.cfg_err, bus.busy, bus.dp_last}, {bus.round, bus.rk_idx}, bus.shift_sel);
        end
        checks++;
        if ({bus.dp_state, bus.dp_rk, bus.out_data} !== 384'h0) begin
            errors++; $display("FAIL midop_data: dp_state=%h dp_rk=%h out_data=%h expected 0", bus.dp_state, bus.dp_rk, bus.out_data);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midop_discard: got %0d active cycles expected 0", seen); end
        pt = rand128();
        run_block(pt, 0, ct, lat);
        checks++;
        if (ct !== ref_encrypt(pt, 8'hE4) || lat !== 22) begin
            errors++; $display("FAIL midop_next: got %h lat %0d expected %h lat 22", ct, lat, ref_encrypt(pt, 8'hE4));
        end
    endtask

    task automatic test_simultaneous;
        logic [127:0] pt, ct;
        int t0, lat;
        set_key(rand128());
        pt = rand128(); key_delay = 0; bus.out_ready = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_shift = 8'h00;
        bus.in_valid = 1'b1; bus.in_data = pt; t0 = cyc;
        @(negedge clk);
        bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.cfg_err, bus.shift_sel} !== {2'b10, 8'h00}) begin
            errors++; $display("FAIL simul_accept: busy=%b cfg_err=%b shift_sel=%h expected 1 0 00", bus.busy, bus.cfg_err, bus.shift_sel);
        end
        wait_out(t0, lat, ct);
        checks++;
        if (ct !== ref_encrypt(pt, 8'h00) || lat !== 22) begin
            errors++; $display("FAIL simul_ct: got %h lat %0d expected %h lat 22", ct, lat, ref_encrypt(pt, 8'h00));
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [127:0] pt, ct;
        logic [7:0] sel;
        int lat, dly;
        for (int b = 0; b < 6; b++) begin
            sel = 8'($urandom);
            bus.cfg_we = 1'b1; bus.cfg_shift = sel;
            @(negedge clk);
            bus.cfg_we = 1'b0;
            set_key(rand128());
            pt = rand128(); dly = $urandom_range(0, 4);
            run_block(pt, dly, ct, lat);
            checks++;
            if (ct !== ref_encrypt(pt, sel) || lat !== 22 + 11*dly || bus.shift_sel !== sel) begin
                errors++;
                $display("FAIL random_%0d: got %h lat %0d sel %h expected %h lat %0d sel %h", b, ct, lat, bus.shift_sel, ref_encrypt(pt, sel), 22 + 11*dly, sel);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_shift = 8'h00;
        for (int r = 0; r < 16; r++) rkeys[r] = '0;
        test_reset;
        test_fips;
        test_key_stalls;
        test_backpressure;
        test_cfg_lock;
        test_reset_midop;
        test_simultaneous;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
